// File: rtl/frac_pwm_mc_if.sv
// Control/status bundle for the multi-channel fractional PWM.
// The master side drives settings and strobes; the slave side is the PWM core.
interface frac_pwm_mc_if #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned NCH   = 4
);
   logic                 en;
   logic                 ld;
   logic [WIDTH-1:0]     no_in;
   logic [NCH*WIDTH-1:0] n_in;
   logic [NCH*WIDTH-1:0] mf_in;
   logic                 dmode_in;
   logic [NCH-1:0]       q_out;
   logic                 ld_pend;
   logic                 frame_tc;
   logic                 period_tc;

   modport master (
      output en, ld, no_in, n_in, mf_in, dmode_in,
      input  q_out, ld_pend, frame_tc, period_tc
   );

   modport slave (
      input  en, ld, no_in, n_in, mf_in, dmode_in,
      output q_out, ld_pend, frame_tc, period_tc
   );
endinterface

// File: rtl/frac_pwm_mc.sv
// Multi-channel fractional PWM. All channels share one period counter and one
// frame counter. Settings are double-buffered: captured into a shadow set on ld
// and copied into the active set only at a frame boundary, so a frame always
// averages to exactly coarse + fine/2^FSZE counts per period.
module frac_pwm_mc #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned FSZE  = 6,
   parameter int unsigned NCH   = 4
) (
   input logic          sys_clk,
   input logic          rst,
   frac_pwm_mc_if.slave bus
);

   logic [WIDTH-1:0]        period_cnt_q, period_cnt_d;
   logic [FSZE-1:0]         mcnt_q, mcnt_d, mcnt_next, sel;
   logic                    tc, fb, commit;
   logic                    ld_pend_q, ld_pend_d;
   logic [WIDTH-1:0]        sh_no_q, sh_no_d, act_no_q, act_no_d;
   logic [NCH*WIDTH-1:0]    sh_n_q, sh_n_d, act_n_q, act_n_d;
   logic [NCH*WIDTH-1:0]    sh_mf_q, sh_mf_d, act_mf_q, act_mf_d;
   logic                    sh_dmode_q, sh_dmode_d, act_dmode_q, act_dmode_d;
   logic [NCH-1:0][WIDTH:0] w_q, w_d, wcnt_q, wcnt_d;

   function automatic logic [FSZE-1:0] bitrev(input logic [FSZE-1:0] v);
      logic [FSZE-1:0] r;
      for (int i = 0; i < int'(FSZE); i++) begin
         r[i] = v[FSZE-1-i];
      end
      return r;
   endfunction

   // High time for one period: clamp(N + floor(mf), 0, No) plus one dither count.
   function automatic logic [WIDTH:0] calc_w(input logic [WIDTH-1:0] n,
                                             input logic [WIDTH-1:0] mf,
                                             input logic [WIDTH-1:0] no,
                                             input logic [FSZE-1:0]  s);
      logic signed [WIDTH+1:0] sum;
      logic [WIDTH-1:0]        coarse;
      logic [WIDTH:0]          wsum;
      logic [WIDTH:0]          wmax;
      sum = $signed({2'b00, n}) + ($signed({{2{mf[WIDTH-1]}}, mf}) >>> FSZE);
      if (sum[WIDTH+1]) begin
         coarse = '0;
      end else if (sum > $signed({2'b00, no})) begin
         coarse = no;
      end else begin
         coarse = sum[WIDTH-1:0];
      end
      wsum = {1'b0, coarse} + {{WIDTH{1'b0}}, (s < mf[FSZE-1:0])};
      wmax = {1'b0, no} + (WIDTH+1)'(1);
      return (wsum > wmax) ? wmax : wsum;
   endfunction

   // Shared period and frame counters.
   always_comb begin
      tc        = bus.en & (period_cnt_q == '0);
      fb        = tc & (mcnt_q == '0);
      commit    = fb & ld_pend_q;
      mcnt_next = (mcnt_q == '0) ? '1 : mcnt_q - FSZE'(1);
      // A width loaded at tc is displayed while mcnt holds its next value,
      // so the dither phase is taken from that value.
      sel       = act_dmode_q ? bitrev(mcnt_next) : mcnt_next;
      period_cnt_d = period_cnt_q;
      mcnt_d       = mcnt_q;
      if (!bus.en) begin
         period_cnt_d = '0;
         mcnt_d       = '0;
      end else if (tc) begin
         period_cnt_d = act_no_q;
         mcnt_d       = mcnt_next;
      end else begin
         period_cnt_d = period_cnt_q - WIDTH'(1);
      end
   end

   // Shadow capture and frame-boundary commit; a coincident ld stays pending.
   always_comb begin
      sh_no_d     = sh_no_q;
      sh_n_d      = sh_n_q;
      sh_mf_d     = sh_mf_q;
      sh_dmode_d  = sh_dmode_q;
      act_no_d    = act_no_q;
      act_n_d     = act_n_q;
      act_mf_d    = act_mf_q;
      act_dmode_d = act_dmode_q;
      if (bus.ld) begin
         sh_no_d    = bus.no_in;
         sh_n_d     = bus.n_in;
         sh_mf_d    = bus.mf_in;
         sh_dmode_d = bus.dmode_in;
      end
      if (commit) begin
         act_no_d    = sh_no_q;
         act_n_d     = sh_n_q;
         act_mf_d    = sh_mf_q;
         act_dmode_d = sh_dmode_q;
      end
      ld_pend_d = bus.ld | (ld_pend_q & ~commit);
   end

   // Per-channel width pipeline register and pulse counters.
   always_comb begin
      for (int k = 0; k < int'(NCH); k++) begin
         w_d[k] = calc_w(act_n_q[k*WIDTH +: WIDTH], act_mf_q[k*WIDTH +: WIDTH], act_no_q, sel);
         wcnt_d[k] = wcnt_q[k];
         if (!bus.en) begin
            wcnt_d[k] = '0;
         end else if (tc) begin
            wcnt_d[k] = w_q[k];
         end else if (wcnt_q[k] != '0) begin
            wcnt_d[k] = wcnt_q[k] - (WIDTH+1)'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         period_cnt_q <= '0;
         mcnt_q       <= '0;
         ld_pend_q    <= 1'b0;
         sh_no_q      <= '0;
         sh_n_q       <= '0;
         sh_mf_q      <= '0;
         sh_dmode_q   <= 1'b0;
         act_no_q     <= '0;
         act_n_q      <= '0;
         act_mf_q     <= '0;
         act_dmode_q  <= 1'b0;
         w_q          <= '0;
         wcnt_q       <= '0;
      end else begin
         period_cnt_q <= period_cnt_d;
         mcnt_q       <= mcnt_d;
         ld_pend_q    <= ld_pend_d;
         sh_no_q      <= sh_no_d;
         sh_n_q       <= sh_n_d;
         sh_mf_q      <= sh_mf_d;
         sh_dmode_q   <= sh_dmode_d;
         act_no_q     <= act_no_d;
         act_n_q      <= act_n_d;
         act_mf_q     <= act_mf_d;
         act_dmode_q  <= act_dmode_d;
         w_q          <= w_d;
         wcnt_q       <= wcnt_d;
      end
   end

   // Outputs decoded from registered state.
   always_comb begin
      for (int k = 0; k < int'(NCH); k++) begin
         bus.q_out[k] = (wcnt_q[k] != '0);
      end
   end

   assign bus.ld_pend   = ld_pend_q;
   assign bus.frame_tc  = commit;
   assign bus.period_tc = tc;

endmodule

// File: tb/tb_frac_pwm_mc.sv
// Directed bench for frac_pwm_mc (WIDTH=8, FSZE=2, NCH=2, No=9 throughout).
// Measured widths are listed in period order after a commit: the periods in
// which the frame counter reads 2, 1, 0, then 3.
module tb_frac_pwm_mc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned FSZE  = 2;
   localparam int unsigned NCH   = 2;

   typedef struct packed {
      logic [7:0]      n0;
      logic [7:0]      mf0;
      logic [7:0]      n1;
      logic [7:0]      mf1;
      logic            dmode;
      logic [3:0][7:0] w0;
      logic [3:0][7:0] w1;
   } vec_t;

   logic sys_clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   vec_t vecs [7];

   frac_pwm_mc_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

   frac_pwm_mc #(.WIDTH(WIDTH), .FSZE(FSZE), .NCH(NCH)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input int n0, input int m0, input int n1, input int m1,
                               input bit dm, input int a0, input int b0, input int c0,
                               input int d0, input int a1, input int b1, input int c1,
                               input int d1);
      vec_t v;
      v.n0 = 8'(n0);   v.mf0 = 8'(m0);
      v.n1 = 8'(n1);   v.mf1 = 8'(m1);
      v.dmode = dm;
      v.w0[0] = 8'(a0); v.w0[1] = 8'(b0); v.w0[2] = 8'(c0); v.w0[3] = 8'(d0);
      v.w1[0] = 8'(a1); v.w1[1] = 8'(b1); v.w1[2] = 8'(c1); v.w1[3] = 8'(d1);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic load(input vec_t v);
      bus.ld       = 1'b1;
      bus.n_in     = {v.n1, v.n0};
      bus.mf_in    = {v.mf1, v.mf0};
      bus.dmode_in = v.dmode;
      tick();
      bus.ld = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int g = 0;
      while (!bus.frame_tc && g < 60) begin
         tick();
         g++;
      end
      check(name, int'(bus.frame_tc), 1);
   endtask

   // Waits for period_tc, then counts high cycles of each channel over one period.
   task automatic measure(input string name, output int c0, output int c1, output int fp);
      int g = 0;
      while (!bus.period_tc && g < 40) begin
         tick();
         g++;
      end
      check({name, "_tc_wait"}, int'(bus.period_tc), 1);
      c0 = 0;
      c1 = 0;
      fp = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.q_out[0]) c0++;
         if (bus.q_out[1]) c1++;
         if (bus.frame_tc) fp++;
      end
   endtask

   initial begin
      int   c0, c1, fp, fsum;
      vec_t v1, v2, v5;
      n_tests = 0;
      n_fail  = 0;

      //          n0 mf0  n1  mf1 dm   ch0 widths      ch1 widths
      vecs[0] = mk(3,  0,  0,   0, 0,   3,  3,  3, 3,   0,  0,  0, 0);
      vecs[1] = mk(3,  5,  5,  -1, 0,   4,  4,  5, 4,   5,  5,  5, 4);
      vecs[2] = mk(3,  2,  1,   6, 0,   3,  4,  4, 3,   2,  3,  3, 2);
      vecs[3] = mk(3,  2,  1,   6, 1,   4,  3,  4, 3,   3,  2,  3, 2);
      vecs[4] = mk(8, 12,  2, -12, 0,   9,  9,  9, 9,   0,  0,  0, 0);
      vecs[5] = mk(8, 15,  0,  -1, 0,  10, 10, 10, 9,   1,  1,  1, 0);
      vecs[6] = mk(0,  1,  9,   3, 1,   0,  0,  1, 0,  10, 10, 10, 9);
      v1 = vecs[0];
      v2 = vecs[1];
      v5 = vecs[4];

      // Reset state
      rst = 1'b1;
      bus.en = 1'b0;
      bus.ld = 1'b0;
      bus.no_in = 8'd9;
      bus.n_in = '0;
      bus.mf_in = '0;
      bus.dmode_in = 1'b0;
      #12;
      check("rst_q_out", int'(bus.q_out), 0);
      check("rst_ld_pend", int'(bus.ld_pend), 0);
      check("rst_frame_tc", int'(bus.frame_tc), 0);
      check("rst_period_tc", int'(bus.period_tc), 0);
      tick();
      rst = 1'b0;

      // Bring-up: first commit happens on the enabling cycle
      load(v1);
      check("bringup_ld_pend", int'(bus.ld_pend), 1);
      bus.en = 1'b1;
      #1;
      check("bringup_period_tc", int'(bus.period_tc), 1);
      check("bringup_frame_tc", int'(bus.frame_tc), 1);
      tick();
      check("bringup_commit_ld_pend", int'(bus.ld_pend), 0);

      // Table: load mid-frame, wait for commit, measure one full frame
      for (int i = 0; i < 7; i++) begin
         load(vecs[i]);
         check($sformatf("v%0d_ld_pend_set", i), int'(bus.ld_pend), 1);
         wait_frame($sformatf("v%0d_frame_tc", i));
         tick();
         check($sformatf("v%0d_ld_pend_clr", i), int'(bus.ld_pend), 0);
         fsum = 0;
         for (int p = 0; p < 4; p++) begin
            measure($sformatf("v%0d_p%0d", i, p), c0, c1, fp);
            check($sformatf("v%0d_ch0_p%0d", i, p), c0, int'(vecs[i].w0[p]));
            check($sformatf("v%0d_ch1_p%0d", i, p), c1, int'(vecs[i].w1[p]));
            fsum += fp;
         end
         check($sformatf("v%0d_no_extra_frame_tc", i), fsum, 0);
      end

      // Mid-frame ld leaves the active pattern alone until the frame boundary
      load(v1);
      check("mid_ld_pend", int'(bus.ld_pend), 1);
      measure("mid_a", c0, c1, fp);
      check("mid_a_ch0", c0, 0);
      check("mid_a_ch1", c1, 10);
      measure("mid_b", c0, c1, fp);
      check("mid_b_ch0", c0, 1);
      check("mid_b_ch1", c1, 10);
      check("mid_b_ld_pend", int'(bus.ld_pend), 1);
      check("fb_frame_tc", int'(bus.frame_tc), 1);

      // ld on the boundary cycle: old shadow commits, new one stays pending
      load(v5);
      check("fb_ld_pend_kept", int'(bus.ld_pend), 1);
      measure("fb_a", c0, c1, fp);
      check("fb_a_ch0_old_shadow", c0, 3);
      check("fb_a_ch1_old_shadow", c1, 0);
      measure("fb_b", c0, c1, fp);
      measure("fb_c", c0, c1, fp);
      check("fb_c_ch0", c0, 3);
      check("fb2_frame_tc", int'(bus.frame_tc), 1);
      tick();
      check("fb2_ld_pend_clr", int'(bus.ld_pend), 0);
      measure("fb_d", c0, c1, fp);
      check("fb_d_ch0_new", c0, 9);
      check("fb_d_ch1_new", c1, 0);

      // Asynchronous reset mid-period discards the pending shadow
      load(v2);
      tick();
      check("pre_rst_q0", int'(bus.q_out[0]), 1);
      check("pre_rst_ld_pend", int'(bus.ld_pend), 1);
      rst = 1'b1;
      #1;
      check("rst_async_q_out", int'(bus.q_out), 0);
      check("rst_async_ld_pend", int'(bus.ld_pend), 0);
      tick();
      tick();
      rst = 1'b0;

      // Reload after reset; first period after commit still uses zeroed settings
      load(v2);
      wait_frame("rl_frame_tc");
      tick();
      measure("rl_skip", c0, c1, fp);
      measure("rl_a", c0, c1, fp);
      check("rl_a_ch0", c0, 4);
      check("rl_a_ch1", c1, 5);
      measure("rl_b", c0, c1, fp);
      check("rl_b_ch0", c0, 5);
      check("rl_b_ch1", c1, 5);

      // en low clears the outputs; en high restarts at the top of a frame
      tick();
      tick();
      tick();
      check("pre_en_q0", int'(bus.q_out[0]), 1);
      bus.en = 1'b0;
      tick();
      check("en0_q_out", int'(bus.q_out), 0);
      check("en0_period_tc", int'(bus.period_tc), 0);
      for (int i = 0; i < 4; i++) tick();
      check("en0_q_out_held", int'(bus.q_out), 0);
      bus.en = 1'b1;
      #1;
      check("en1_period_tc", int'(bus.period_tc), 1);
      check("en1_frame_tc", int'(bus.frame_tc), 0);
      for (int p = 0; p < 4; p++) begin
         measure($sformatf("en1_p%0d", p), c0, c1, fp);
         check($sformatf("en1_ch0_p%0d", p), c0, (p == 3) ? 5 : 4);
         check($sformatf("en1_ch1_p%0d", p), c1, (p == 0) ? 4 : 5);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
